reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 9 +
 rtl/reg_file_cell.sv | 32 +++
 rtl/reg_file.sv | 63 ++++++
 tb/tb_reg_file.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared datapath constants for the register file: default widths and the
// index of the hardwired-zero register.
package reg_file_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned ADDR_W_DEF   = 5;
    localparam int unsigned ZERO_REG_IDX = 0;

endpackage : reg_file_pkg

// File: rtl/reg_file_cell.sv
// Enable-hold storage register: a hold/load mux feeding a bank of D flops,
// cleared asynchronously by the active-low reset.
module reg_file_cell
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        data_d = load_i ? d_i : data_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule : reg_file_cell

// File: rtl/reg_file.sv
// Two-read, one-write register file with a hardwired-zero register 0,
// combinational reads and a same-cycle write-to-read bypass.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);

    localparam int unsigned       NUM_REGS  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG_IDX);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0] load_sel;
    logic                wr_live;

    // Gating with reset keeps an unknown wr_en from reaching any cell or the bypass.
    assign wr_live = reset && wr_en && (wr_addr != ZERO_ADDR);

    assign regs[0]     = '0;
    assign load_sel[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cell
            assign load_sel[gi] = wr_live && (wr_addr == ADDR_W'(gi));

            reg_file_cell #(
                .DATA_W (DATA_W)
            ) u_cell (
                .clock  (clock),
                .reset  (reset),
                .load_i (load_sel[gi]),
                .d_i    (wr_data),
                .q_o    (regs[gi])
            );
        end
    endgenerate

    always_comb begin
        rd_data_a = '0;
        if (reset) begin
            rd_data_a = (wr_live && (rd_addr_a == wr_addr)) ? wr_data : regs[rd_addr_a];
        end
    end

    always_comb begin
        rd_data_b = '0;
        if (reset) begin
            rd_data_b = (wr_live && (rd_addr_b == wr_addr)) ? wr_data : regs[rd_addr_b];
        end
    end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes expected read-port values,
// a monitor pops and compares them whenever a sample is presented.
module tb_reg_file;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clock;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;

    typedef struct {
        string         name;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
    } exp_t;

    exp_t          sb_q[$];
    event          present;
    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] model [32];

    reg_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: one comparison per presented sample.
    initial begin
        forever begin
            @(present);
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_underflow: sample with no expectation");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (rd_data_a !== e.exp_a || rd_data_b !== e.exp_b) begin
                    failures++;
                    $display("FAIL %s: got a=%h b=%h, want a=%h b=%h",
                             e.name, rd_data_a, rd_data_b, e.exp_a, e.exp_b);
                end else begin
                    $display("ok   %s: a=%h b=%h", e.name, rd_data_a, rd_data_b);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic expect_rd(input string name, input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        exp_t e;
        e.name  = name;
        e.exp_a = ea;
        e.exp_b = eb;
        sb_q.push_back(e);
        -> present;
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clock);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        if (a != '0) model[a] = d;
    endtask

    task automatic sweep(input string name);
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = AW'(i);
            rd_addr_b = AW'(31 - i);
            expect_rd($sformatf("%s[%0d]", name, i), model[i], model[31 - i]);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
        reset     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;

        // In reset: a write plus matching read must neither bypass nor commit.
        @(negedge clock);
        wr_en     = 1'b1;
        wr_addr   = 5'd5;
        wr_data   = 32'hCAFE_0001;
        rd_addr_a = 5'd5;
        rd_addr_b = 5'd5;
        expect_rd("reset_no_bypass", 32'h0, 32'h0);
        @(posedge clock);
        #1;
        expect_rd("reset_no_write", 32'h0, 32'h0);
        wr_en = 1'b0;

        @(negedge clock);
        reset = 1'b1;
        sweep("reset_sweep");

        // First edge after release accepts a write.
        do_write(5'd4, 32'h0000_0044);
        rd_addr_a = 5'd4;
        rd_addr_b = 5'd0;
        expect_rd("first_write_after_release", 32'h0000_0044, 32'h0);

        do_write(5'd5, 32'hDEAD_BEEF);
        rd_addr_a = 5'd5;
        rd_addr_b = 5'd6;
        expect_rd("write_read_r5", 32'hDEAD_BEEF, 32'h0);

        // Zero register ignores writes before and after the edge.
        @(negedge clock);
        wr_en     = 1'b1;
        wr_addr   = 5'd0;
        wr_data   = 32'hFFFF_FFFF;
        rd_addr_a = 5'd0;
        rd_addr_b = 5'd5;
        expect_rd("zero_pre_edge", 32'h0, 32'hDEAD_BEEF);
        @(posedge clock);
        #1;
        expect_rd("zero_post_edge", 32'h0, 32'hDEAD_BEEF);
        wr_en = 1'b0;

        do_write(5'd7, 32'h1);
        @(negedge clock);
        wr_en     = 1'b1;
        wr_addr   = 5'd7;
        wr_data   = 32'h2;
        rd_addr_a = 5'd7;
        rd_addr_b = 5'd7;
        expect_rd("bypass_pre_edge", 32'h2, 32'h2);
        @(posedge clock);
        #1;
        wr_en    = 1'b0;
        model[7] = 32'h2;
        expect_rd("bypass_post_edge", 32'h2, 32'h2);

        // Bypass on one port only; the other port sees stored data.
        @(negedge clock);
        wr_en     = 1'b1;
        wr_addr   = 5'd10;
        wr_data   = 32'h0BAD_F00D;
        rd_addr_a = 5'd10;
        rd_addr_b = 5'd7;
        expect_rd("bypass_port_a_only", 32'h0BAD_F00D, 32'h2);
        wr_en = 1'b0;
        expect_rd("bypass_dropped_no_edge", 32'h0, 32'h2);

        do_write(5'd31, 32'hA5A5_A5A5);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            wr_en   = 1'b0;
            wr_addr = AW'($urandom_range(0, 31));
            wr_data = $urandom;
        end
        @(negedge clock);
        sweep("hold_sweep");

        do_write(5'd3, 32'h0000_1234);
        @(negedge clock);
        rd_addr_a = 5'd3;
        rd_addr_b = 5'd31;
        expect_rd("async_before", 32'h0000_1234, 32'hA5A5_A5A5);
        #1;
        reset = 1'b0;
        #1;
        expect_rd("async_drop", 32'h0, 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        @(posedge clock);
        #1;
        expect_rd("async_after_release", 32'h0, 32'h0);

        // Reset held across the edge aborts the in-flight write.
        @(negedge clock);
        wr_en     = 1'b1;
        wr_addr   = 5'd9;
        wr_data   = 32'h5555_5555;
        rd_addr_a = 5'd9;
        rd_addr_b = 5'd9;
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        reset = 1'b1;
        #1;
        expect_rd("aborted_write_r9", 32'h0, 32'h0);

        #2;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d left, want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_file
